// File: rtl/asp_irq_ctrl.sv
// Edge-detecting interrupt controller: latches rising edges of level sources,
// masks them through a CSR block and forwards one request at a time to the host.
module asp_irq_ctrl #(
  parameter int NUM_INTERRUPT_LINES = 4,
  parameter int NUM_IRQ_USED        = 3,
  parameter int CSR_DATA_WIDTH      = 64,
  localparam int ID_W = (NUM_INTERRUPT_LINES > 1) ? $clog2(NUM_INTERRUPT_LINES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_INTERRUPT_LINES-1:0] irq_in,
  input  logic [1:0]                     csr_address,
  input  logic                           csr_write,
  input  logic                           csr_read,
  input  logic [CSR_DATA_WIDTH-1:0]      csr_writedata,
  output logic [CSR_DATA_WIDTH-1:0]      csr_readdata,
  output logic                           csr_readdatavalid,
  output logic                           irq_valid,
  output logic [ID_W-1:0]                irq_id,
  input  logic                           irq_ack
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_ENABLE = 2'd1;
  localparam logic [1:0] ADDR_CLEAR  = 2'd2;
  localparam logic [1:0] ADDR_RAW    = 2'd3;

  logic [NUM_INTERRUPT_LINES-1:0] irq_q_q, irq_q_d;
  logic [NUM_IRQ_USED-1:0]        pending_q, pending_d;
  logic [NUM_IRQ_USED-1:0]        in_service_q, in_service_d;
  logic [NUM_IRQ_USED-1:0]        enable_q, enable_d;
  logic [0:0]                     state_q, state_d;
  logic                           irq_valid_q, irq_valid_d;
  logic [ID_W-1:0]                irq_id_q, irq_id_d;
  logic [CSR_DATA_WIDTH-1:0]      csr_readdata_q, csr_readdata_d;
  logic                           csr_readdatavalid_q, csr_readdatavalid_d;

  logic [NUM_IRQ_USED-1:0] rise;
  logic [NUM_IRQ_USED-1:0] clr;
  logic [NUM_IRQ_USED-1:0] ack_set;
  logic [NUM_IRQ_USED-1:0] candidate;
  logic [ID_W-1:0]         lowest;
  logic                    unused_wdata;

  assign unused_wdata = ^csr_writedata[CSR_DATA_WIDTH-1:NUM_IRQ_USED];

  always_comb begin
    irq_q_d = irq_in;
    rise    = irq_in[NUM_IRQ_USED-1:0] & ~irq_q_q[NUM_IRQ_USED-1:0];

    clr      = (csr_write && csr_address == ADDR_CLEAR) ? csr_writedata[NUM_IRQ_USED-1:0] : '0;
    enable_d = (csr_write && csr_address == ADDR_ENABLE) ? csr_writedata[NUM_IRQ_USED-1:0]
                                                         : enable_q;

    ack_set = '0;
    for (int i = 0; i < NUM_IRQ_USED; i++) begin
      if (state_q == REQ && irq_ack && irq_id_q == ID_W'(i)) ack_set[i] = 1'b1;
    end

    // A rising edge outranks a same-cycle CLEAR, so the line comes back as pending.
    pending_d    = (pending_q & ~clr) | rise;
    in_service_d = (in_service_q & ~clr) | ack_set;

    candidate = pending_q & enable_q & ~in_service_q;
    lowest    = '0;
    for (int i = NUM_IRQ_USED - 1; i >= 0; i--) begin
      if (candidate[i]) lowest = ID_W'(i);
    end

    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    case (state_q)
      IDLE: begin
        if (|candidate) begin
          state_d     = REQ;
          irq_valid_d = 1'b1;
          irq_id_d    = lowest;
        end
      end
      default: begin
        // The request is never retracted; only an ack ends it.
        if (irq_ack) begin
          state_d     = IDLE;
          irq_valid_d = 1'b0;
        end
      end
    endcase

    csr_readdatavalid_d = csr_read;
    csr_readdata_d      = '0;
    if (csr_read) begin
      case (csr_address)
        ADDR_STATUS: csr_readdata_d[NUM_IRQ_USED-1:0]        = pending_q;
        ADDR_ENABLE: csr_readdata_d[NUM_IRQ_USED-1:0]        = enable_q;
        ADDR_RAW:    csr_readdata_d[NUM_INTERRUPT_LINES-1:0] = irq_q_q;
        default:     csr_readdata_d                          = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q_q             <= '0;
      pending_q           <= '0;
      in_service_q        <= '0;
      enable_q            <= '0;
      state_q             <= IDLE;
      irq_valid_q         <= 1'b0;
      irq_id_q            <= '0;
      csr_readdata_q      <= '0;
      csr_readdatavalid_q <= 1'b0;
    end else begin
      irq_q_q             <= irq_q_d;
      pending_q           <= pending_d;
      in_service_q        <= in_service_d;
      enable_q            <= enable_d;
      state_q             <= state_d;
      irq_valid_q         <= irq_valid_d;
      irq_id_q            <= irq_id_d;
      csr_readdata_q      <= csr_readdata_d;
      csr_readdatavalid_q <= csr_readdatavalid_d;
    end
  end

  assign irq_valid         = irq_valid_q;
  assign irq_id            = irq_id_q;
  assign csr_readdata      = csr_readdata_q;
  assign csr_readdatavalid = csr_readdatavalid_q;

endmodule
